imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 124 ++++++++++++
 tb/tb_imem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Two-requester instruction-memory arbiter (fetch vs. loader) with one-cycle response path.
// Define IMEM_ARB_ROUND_ROBIN_EN for alternating contention grants; default is fixed priority with a starvation guard.
module imem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DEPTH      = 1024,
  parameter int STARVE_MAX = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     f_valid,
  output logic                                     f_ready,
  input  logic [ADDR_W-1:0]                        f_addr,
  output logic                                     f_rvalid,
  output logic [31:0]                              f_rdata,
  output logic                                     f_err,
  input  logic                                     l_valid,
  output logic                                     l_ready,
  input  logic                                     l_we,
  input  logic [ADDR_W-1:0]                        l_addr,
  input  logic [31:0]                              l_wdata,
  output logic                                     l_rvalid,
  output logic [31:0]                              l_rdata,
  output logic                                     l_err,
  output logic                                     m_en,
  output logic                                     m_we,
  output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] m_idx,
  output logic [31:0]                              m_wdata,
  input  logic [31:0]                              m_rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RESP_F, RESP_L} state_t;

  state_t            state_reg, state_next;
  logic              err_reg, err_next;
  logic              data_reg, data_next;
  logic              fetch_wins;
  logic              f_xfer, l_xfer, any_xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_bad;

`ifdef IMEM_ARB_ROUND_ROBIN_EN
  // Points at the requester that wins the next contended cycle.
  logic rr_fetch_reg, rr_fetch_next;

  assign fetch_wins = rr_fetch_reg;

  always_comb begin
    rr_fetch_next = rr_fetch_reg;
    if (f_valid && l_valid)
      rr_fetch_next = ~f_xfer;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rr_fetch_reg <= 1'b1;
    else        rr_fetch_reg <= rr_fetch_next;
  end
`else
  localparam int CNT_W = $clog2(STARVE_MAX + 2);

  logic [CNT_W-1:0] starve_reg, starve_next;

  assign fetch_wins = (starve_reg == CNT_W'(STARVE_MAX));

  always_comb begin
    starve_next = starve_reg;
    if (!f_valid || f_xfer)
      starve_next = '0;
    else if (l_xfer && (starve_reg != CNT_W'(STARVE_MAX)))
      starve_next = starve_reg + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) starve_reg <= '0;
    else        starve_reg <= starve_next;
  end
`endif

  assign f_ready  = rst_n & f_valid & (~l_valid | fetch_wins);
  assign l_ready  = rst_n & l_valid & ~f_ready;
  assign f_xfer   = f_valid & f_ready;
  assign l_xfer   = l_valid & l_ready;
  assign any_xfer = f_xfer | l_xfer;

  // Misaligned or out-of-range requests complete with an error and never touch memory.
  assign sel_addr = f_xfer ? f_addr : l_addr;
  assign sel_bad  = (sel_addr[1:0] != 2'b00) ||
                    ({2'b00, sel_addr[ADDR_W-1:2]} >= ADDR_W'(DEPTH));

  assign m_en    = any_xfer & ~sel_bad;
  assign m_we    = m_en & l_xfer & l_we;
  assign m_idx   = sel_addr[IDX_W+1:2];
  assign m_wdata = l_wdata;

  always_comb begin
    state_next = IDLE;
    err_next   = any_xfer & sel_bad;
    data_next  = m_en & ~m_we;
    if (f_xfer)      state_next = RESP_F;
    else if (l_xfer) state_next = RESP_L;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      err_reg   <= 1'b0;
      data_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
      data_reg  <= data_next;
    end
  end

  // Responses are masked while reset is asserted so a pending one is dropped at once.
  assign f_rvalid = rst_n & (state_reg == RESP_F);
  assign l_rvalid = rst_n & (state_reg == RESP_L);
  assign f_err    = f_rvalid & err_reg;
  assign l_err    = l_rvalid & err_reg;
  assign f_rdata  = (f_rvalid & data_reg) ? m_rdata : 32'h0;
  assign l_rdata  = (l_rvalid & data_reg) ? m_rdata : 32'h0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_imem_arbiter;
  localparam int AW    = 16;
  localparam int DEPTH = 64;
  localparam int SM    = 4;
  localparam int IW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          f_valid, f_ready, f_rvalid, f_err;
  logic [AW-1:0] f_addr;
  logic [31:0]   f_rdata;
  logic          l_valid, l_ready, l_we, l_rvalid, l_err;
  logic [AW-1:0] l_addr;
  logic [31:0]   l_wdata, l_rdata;
  logic          m_en, m_we;
  logic [IW-1:0] m_idx;
  logic [31:0]   m_wdata, m_rdata;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  int          loss_cnt;
  bit          rr_fetch;
  bit          pend_v, pend_f, pend_err;
  logic [31:0] pend_data;

  imem_arbiter #(.ADDR_W(AW), .DEPTH(DEPTH), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_valid(f_valid), .f_ready(f_ready), .f_addr(f_addr),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
    .l_valid(l_valid), .l_ready(l_ready), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
    .m_en(m_en), .m_we(m_we), .m_idx(m_idx), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Synchronous memory the arbiter drives: registered read, one-cycle latency.
  initial begin
    logic [31:0] env_mem [DEPTH];
    for (int i = 0; i < DEPTH; i++) env_mem[i] = init_word(i);
    m_rdata = 32'h0;
    forever begin
      @(posedge clk);
      if (m_en) begin
        if (m_we) env_mem[m_idx] <= m_wdata;
        else      m_rdata <= env_mem[m_idx];
      end
    end
  end

  function automatic bit addr_bad(logic [AW-1:0] a);
    return ((int'(a) % 4) != 0) || ((int'(a) / 4) >= DEPTH);
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 15) == 0) return AW'($urandom);
    return AW'($urandom_range(0, DEPTH - 1) * 4);
  endfunction

  task automatic model_reset();
    loss_cnt = 0;
    rr_fetch = 1'b1;
    pend_v   = 1'b0;
  endtask

  // Drives one cycle, scores grant / memory port / response against the model, then advances.
  task automatic step(input bit fv, input logic [AW-1:0] fa, input bit lv, input bit lwe,
                      input logic [AW-1:0] la, input logic [31:0] lwd,
                      output bit gf, output bit obs_f);
    bit fwin, gl, bad, wr, exp_en;
    logic [AW-1:0] a;
    int w;
    f_valid = fv; f_addr = fa; l_valid = lv; l_we = lwe; l_addr = la; l_wdata = lwd;
    @(negedge clk);
`ifdef IMEM_ARB_ROUND_ROBIN_EN
    fwin = rr_fetch;
`else
    fwin = (loss_cnt == SM);
`endif
    gf     = fv && (!lv || fwin);
    gl     = lv && !gf;
    obs_f  = f_ready;
    a      = gf ? fa : la;
    bad    = addr_bad(a);
    w      = int'(a) / 4;
    wr     = gl && lwe;
    exp_en = (gf || gl) && !bad;

    checks++;
    if (f_ready !== gf || l_ready !== gl) begin
      errors++;
      $display("FAIL grant: f_ready=%0b l_ready=%0b expected %0b %0b", f_ready, l_ready, gf, gl);
    end
    checks++;
    if (m_en !== exp_en || m_we !== (exp_en && wr)) begin
      errors++;
      $display("FAIL mem_ctrl: m_en=%0b m_we=%0b expected %0b %0b (addr %h)", m_en, m_we, exp_en, exp_en && wr, a);
    end
    if (exp_en) begin
      checks++;
      if (m_idx !== w[IW-1:0] || (wr && m_wdata !== lwd)) begin
        errors++;
        $display("FAIL mem_idx: m_idx=%0d m_wdata=%h expected %0d %h", m_idx, m_wdata, w, lwd);
      end
    end
    checks++;
    if (f_rvalid !== (pend_v && pend_f) || l_rvalid !== (pend_v && !pend_f)) begin
      errors++;
      $display("FAIL strobe: f_rvalid=%0b l_rvalid=%0b expected %0b %0b", f_rvalid, l_rvalid, pend_v && pend_f, pend_v && !pend_f);
    end
    if (pend_v) begin
      checks++;
      if (pend_f && (f_rdata !== pend_data || f_err !== pend_err)) begin
        errors++;
        $display("FAIL f_resp: rdata=%h err=%0b expected %h %0b", f_rdata, f_err, pend_data, pend_err);
      end else if (!pend_f && (l_rdata !== pend_data || l_err !== pend_err)) begin
        errors++;
        $display("FAIL l_resp: rdata=%h err=%0b expected %h %0b", l_rdata, l_err, pend_data, pend_err);
      end
    end

    pend_v    = gf || gl;
    pend_f    = gf;
    pend_err  = (gf || gl) && bad;
    pend_data = (exp_en && !wr) ? ref_mem[w] : 32'h0;
    if (exp_en && wr) ref_mem[w] = lwd;
    if (fv && lv) rr_fetch = !gf;
    if (!fv || gf) loss_cnt = 0;
    else if (gl && loss_cnt < SM) loss_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bit gf, of;
    rst_n = 1'b0;
    f_valid = 1'b1; f_addr = '0; l_valid = 1'b1; l_we = 1'b1; l_addr = AW'(4); l_wdata = 32'h1234_5678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({f_ready, l_ready, m_en, m_we} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: ready/en/we=%b expected 0000", {f_ready, l_ready, m_en, m_we});
    end
    checks++;
    if ({f_rvalid, l_rvalid, f_err, l_err} !== 4'b0000 || f_rdata !== 32'h0 || l_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_resp: strobes/errs=%b rdata=%h/%h expected zeros", {f_rvalid, l_rvalid, f_err, l_err}, f_rdata, l_rdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    step(1, AW'(32'h20), 0, 0, '0, '0, gf, of);
    checks++;
    if (of !== 1'b1) begin
      errors++;
      $display("FAIL first_grant: f_ready=%0b expected 1", of);
    end
    step(0, '0, 0, 0, '0, '0, gf, of);
  endtask

  task automatic test_fetch_seq();
    bit gf, of;
    for (int k = 0; k < 3; k++) begin
      step(1, AW'(4 * k), 0, 0, '0, '0, gf, of);
      checks++;
      if (of !== 1'b1 || f_rvalid !== 1'b1 || f_rdata !== init_word(k)) begin
        errors++;
        $display("FAIL fetch_seq[%0d]: ready=%0b rvalid=%0b rdata=%h expected 1 1 %h", k, of, f_rvalid, f_rdata, init_word(k));
      end
    end
    step(0, '0, 0, 0, '0, '0, gf, of);
  endtask

  task automatic test_write_then_fetch();
    bit gf, of;
    step(0, '0, 1, 1, AW'(32'h10), 32'hDEAD_BEEF, gf, of);
    checks++;
    if (l_rvalid !== 1'b1 || l_rdata !== 32'h0 || l_err !== 1'b0) begin
      errors++;
      $display("FAIL write_resp: rvalid=%0b rdata=%h err=%0b expected 1 00000000 0", l_rvalid, l_rdata, l_err);
    end
    step(1, AW'(32'h10), 0, 0, '0, '0, gf, of);
    checks++;
    if (f_rvalid !== 1'b1 || f_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_then_fetch: rvalid=%0b rdata=%h expected 1 deadbeef", f_rvalid, f_rdata);
    end
    step(0, '0, 0, 0, '0, '0, gf, of);
  endtask

  task automatic test_bad_addr();
    bit gf, of;
    logic [AW-1:0] bad_list [3];
    bad_list[0] = AW'(6);
    bad_list[1] = AW'(4 * DEPTH);
    bad_list[2] = AW'(4 * DEPTH + 8);
    for (int k = 0; k < 2; k++) begin
      step(1, bad_list[k], 0, 0, '0, '0, gf, of);
      checks++;
      if (f_rvalid !== 1'b1 || f_err !== 1'b1 || f_rdata !== 32'h0) begin
        errors++;
        $display("FAIL bad_fetch[%0d]: rvalid=%0b err=%0b rdata=%h expected 1 1 0", k, f_rvalid, f_err, f_rdata);
      end
    end
    step(0, '0, 1, 1, bad_list[2], 32'hCAFE_F00D, gf, of);
    checks++;
    if (l_rvalid !== 1'b1 || l_err !== 1'b1 || l_rdata !== 32'h0) begin
      errors++;
      $display("FAIL bad_load: rvalid=%0b err=%0b rdata=%h expected 1 1 0", l_rvalid, l_err, l_rdata);
    end
    step(0, '0, 0, 0, '0, '0, gf, of);
  endtask

  task automatic test_contention();
    bit gf, of, exp_f;
    rst_n = 1'b0;
    f_valid = 1'b0; l_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      step(1, AW'(0), 1, 0, AW'(8), '0, gf, of);
`ifdef IMEM_ARB_ROUND_ROBIN_EN
      exp_f = ((i % 2) == 0);
`else
      exp_f = ((i % 5) == 4);
`endif
      checks++;
      if (of !== exp_f) begin
        errors++;
        $display("FAIL contention[%0d]: fetch_granted=%0b expected %0b", i, of, exp_f);
      end
    end
    step(0, '0, 0, 0, '0, '0, gf, of);
  endtask

  task automatic test_reset_drop();
    bit gf, of;
    step(1, AW'(0), 0, 0, '0, '0, gf, of);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (f_rvalid !== 1'b0 || f_ready !== 1'b0 || m_en !== 1'b0 || f_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_drop: rvalid=%0b ready=%0b m_en=%0b rdata=%h expected 0 0 0 0", f_rvalid, f_ready, m_en, f_rdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    step(1, AW'(4), 0, 0, '0, '0, gf, of);
    checks++;
    if (of !== 1'b1) begin
      errors++;
      $display("FAIL resume_grant: f_ready=%0b expected 1", of);
    end
    step(0, '0, 0, 0, '0, '0, gf, of);
  endtask

  task automatic test_random();
    bit fv = 0, lv = 0, lwe = 0, gf, of;
    logic [AW-1:0] fa = '0, la = '0;
    logic [31:0]   lwd = '0;
    for (int n = 0; n < 600; n++) begin
      if (!fv) begin fv = ($urandom_range(0, 3) != 0); fa = rand_addr(); end
      if (!lv) begin
        lv  = ($urandom_range(0, 2) == 0);
        lwe = 1'($urandom_range(0, 1));
        la  = rand_addr();
        lwd = $urandom;
      end
      step(fv, fa, lv, lwe, la, lwd, gf, of);
      if (lv && !gf) lv = 0;
      if (gf) fv = 0;
    end
    step(0, '0, 0, 0, '0, '0, gf, of);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    model_reset();
    test_reset();
    test_fetch_seq();
    test_write_then_fetch();
    test_bad_addr();
    test_contention();
    test_reset_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
